// File: rtl/pll_cfg_sequencer_if.sv
// AHB-Lite write-only bus seen from the PLL configuration sequencer.
// The master drives address/control/data; the slave returns HREADY/HRESP.
interface pll_cfg_sequencer_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic [3:0]  HWSTRB;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HBURST, HSIZE, HWSTRB, HWDATA,
        input  HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HBURST, HSIZE, HWSTRB, HWDATA,
        output HREADY, HRESP
    );
endinterface

// File: rtl/pll_cfg_sequencer.sv
// PLL configuration sequencer: on start, snapshots the gain/divider/enable
// words and writes them to four consecutive PLL registers using pipelined
// AHB-Lite single writes. A two-cycle error response aborts the sequence and
// raises a sticky err flag; a clean finish pulses done.
module pll_cfg_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                       h_clk,
    input  logic                       h_reset,
    input  logic                       start,
    input  logic [31:0]                kp,
    input  logic [31:0]                ki,
    input  logic [31:0]                div,
    input  logic                       en,
    pll_cfg_sequencer_if.master        ahb,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        FIRST_ADDR,
        PIPE,
        LAST_DATA,
        ERR_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;      // offset of the address phase on the bus
    logic [31:0] haddr_q, haddr_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hsel_q, hsel_d;
    logic        hwrite_q, hwrite_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        snap_ld;
    logic        drop_bus;
    logic [31:0] kp_q, ki_q, div_q;
    logic        en_q;

    // Register word written at a given offset, taken from the snapshot.
    function automatic logic [31:0] word_at(input logic [1:0] i, input logic [31:0] w0,
                                            input logic [31:0] w1, input logic [31:0] w2,
                                            input logic w3);
        case (i)
            2'd0:    return w0;
            2'd1:    return w1;
            2'd2:    return w2;
            default: return {31'b0, w3};
        endcase
    endfunction

    // Byte address of a register offset within the PLL block.
    function automatic logic [31:0] addr_at(input logic [1:0] i);
        return BASE_ADDR + {28'd0, i, 2'b00};
    endfunction

    // Next-state, bus and status decode; everything holds unless a transfer advances.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
        htrans_d = htrans_q;
        hsel_d   = hsel_q;
        hwrite_d = hwrite_q;
        done_d   = 1'b0;
        err_d    = err_q;
        snap_ld  = 1'b0;
        drop_bus = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_ld  = 1'b1;
                    err_d    = 1'b0;
                    state_d  = FIRST_ADDR;
                    idx_d    = 2'd0;
                    haddr_d  = BASE_ADDR;
                    htrans_d = TRANS_NONSEQ;
                    hsel_d   = 1'b1;
                    hwrite_d = 1'b1;
                end
            end
            FIRST_ADDR, PIPE: begin
                if (ahb.HRESP && !ahb.HREADY) begin
                    // First error cycle: withdraw the pending address phase.
                    state_d  = ERR_WAIT;
                    drop_bus = 1'b1;
                end else if (ahb.HREADY) begin
                    hwdata_d = word_at(idx_q, kp_q, ki_q, div_q, en_q);
                    if (idx_q == 2'd3) begin
                        state_d  = LAST_DATA;
                        drop_bus = 1'b1;
                    end else begin
                        state_d = PIPE;
                        idx_d   = idx_q + 2'd1;
                        haddr_d = addr_at(idx_q + 2'd1);
                    end
                end
            end
            LAST_DATA: begin
                if (ahb.HRESP && !ahb.HREADY) begin
                    state_d = ERR_WAIT;
                end else if (ahb.HREADY) begin
                    state_d = IDLE;
                    if (ahb.HRESP) err_d  = 1'b1;
                    else           done_d = 1'b1;
                end
            end
            ERR_WAIT: begin
                if (ahb.HREADY) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                drop_bus = 1'b1;
            end
        endcase
        if (drop_bus) begin
            htrans_d = TRANS_IDLE;
            hsel_d   = 1'b0;
            hwrite_d = 1'b0;
            haddr_d  = BASE_ADDR;
        end
    end

    // State, bus outputs and status flags.
    always_ff @(posedge h_clk or negedge h_reset) begin
        if (!h_reset) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            haddr_q  <= BASE_ADDR;
            hwdata_q <= 32'd0;
            htrans_q <= TRANS_IDLE;
            hsel_q   <= 1'b0;
            hwrite_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            htrans_q <= htrans_d;
            hsel_q   <= hsel_d;
            hwrite_q <= hwrite_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Input snapshot captured on an accepted start.
    always_ff @(posedge h_clk or negedge h_reset) begin
        if (!h_reset) begin
            kp_q  <= 32'd0;
            ki_q  <= 32'd0;
            div_q <= 32'd0;
            en_q  <= 1'b0;
        end else if (snap_ld) begin
            kp_q  <= kp;
            ki_q  <= ki;
            div_q <= div;
            en_q  <= en;
        end
    end

    assign ahb.HSEL   = hsel_q;
    assign ahb.HADDR  = haddr_q;
    assign ahb.HWRITE = hwrite_q;
    assign ahb.HTRANS = htrans_q;
    assign ahb.HBURST = 3'b000;
    assign ahb.HSIZE  = 3'b010;
    assign ahb.HWSTRB = 4'hF;
    assign ahb.HWDATA = hwdata_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/pll_cfg_sequencer.md
PLL_CFG_SEQUENCER -- requirements
Module: pll_cfg_sequencer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000, which is the base byte address of the PLL register block.
REQ-002 The block SHALL have the following ports, listed as name, direction, width, meaning:
- h_clk, input, 1: the only clock.
- h_reset, input, 1: asynchronous, active-low reset.
- start, input, 1: request to program the PLL.
- kp, input, 32: proportional gain word.
- ki, input, 32: integral gain word.
- div, input, 32: feedback divider word.
- en, input, 1: PLL enable bit.
- HSEL, output, 1: subordinate select.
- HADDR, output, 32: AHB address.
- HWRITE, output, 1: AHB write.
- HTRANS, output, 2: AHB transfer type.
- HBURST, output, 3: AHB burst type.
- HSIZE, output, 3: AHB transfer size.
- HWSTRB, output, 4: AHB write strobes.
- HWDATA, output, 32: AHB write data.
- HREADY, input, 1: transfer complete / wait state.
- HRESP, input, 1: error response.
- busy, output, 1: a sequence is in progress.
- done, output, 1: one-cycle pulse on successful completion.
- err, output, 1: sticky flag, set when a sequence is aborted by an error.

Function
REQ-003 When start=1 is sampled while idle, the block SHALL snapshot kp, ki, div and {31'b0,en}; later changes on these inputs SHALL NOT affect the sequence in progress.
REQ-004 start sampled while busy=1 SHALL be ignored.
REQ-005 The block SHALL issue four single writes in this fixed order, each at BASE_ADDR + offset*4:
- offset 0: kp
- offset 1: ki
- offset 2: div
- offset 3: en
REQ-006 Every write SHALL use HTRANS=NONSEQ (2'b10), HWRITE=1, HBURST=3'b000, HSIZE=3'b010, HWSTRB=4'hF and HSEL=1.
REQ-007 Transfers SHALL be AHB-Lite pipelined:
- The address phase of write N+1 overlaps the data phase of write N.
- HWDATA for write N is driven in the cycle after its address phase is accepted.
REQ-008 States: IDLE, FIRST_ADDR, PIPE, LAST_DATA, ERR_WAIT.
- IDLE -> FIRST_ADDR on accepted start.
- FIRST_ADDR -> PIPE on HREADY=1.
- PIPE -> LAST_DATA once the address of offset 3 is accepted.
- LAST_DATA -> IDLE on HREADY=1 with HRESP=0.
REQ-009 With HREADY=1 throughout, the cycle timing SHALL be:
- start sampled at edge 0;
- address phases in cycles 1-4;
- data phases in cycles 2-5;
- busy=1 in cycles 1-5;
- done=1 in cycle 6 only.
REQ-010 While HREADY=0 and HRESP=0, the block SHALL hold HADDR, HTRANS, HWRITE, HWDATA and all control outputs unchanged.
REQ-011 On HRESP=1 with HREADY=0 (first error cycle), the block SHALL:
- drive HTRANS=IDLE (2'b00) from the next cycle;
- cancel the pending address phase;
- enter ERR_WAIT.
REQ-012 In ERR_WAIT, on HRESP=1 with HREADY=1, the block SHALL:
- set err=1;
- go to IDLE;
- keep busy=0 and done=0;
- issue no further writes.
REQ-013 err SHALL clear on the next accepted start.
REQ-014 done and err=1 SHALL never both be set by the same sequence.
REQ-015 In IDLE the block SHALL drive:
- HTRANS=2'b00, HSEL=0, HWRITE=0;
- HADDR=BASE_ADDR;
- HWDATA held at the last value driven.
REQ-016 If start=1 coincides with the done cycle, the new start SHALL be accepted, so a new FIRST_ADDR follows in the next cycle.

Reset
REQ-017 While h_reset=0, asynchronously:
- state=IDLE;
- HTRANS=2'b00, HSEL=0, HWRITE=0;
- HADDR=BASE_ADDR, HWDATA=0;
- HBURST=0, HSIZE=3'b010, HWSTRB=4'hF;
- busy=0, done=0, err=0;
- snapshot registers=0.
REQ-018 Reset asserted mid-sequence SHALL abandon the sequence immediately. After release, no transfer SHALL occur until a new start.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Nominal: kp=0x100, ki=0x8, div=72, en=1, HREADY=1 -> HADDR 8000_0000/04/08/0C in cycles 1-4; HWDATA 0x100/0x8/0x48/0x1 in cycles 2-5; done=1 in cycle 6 only.
- Wait states: HREADY=0 for 2 cycles during the ki data phase -> HADDR=8000_0008 and HWDATA=0x8 held; done moves to cycle 8.
- Error: two-cycle HRESP on the div data phase -> HTRANS=IDLE after the first error cycle; no write to offset 3; err=1, done=0; err clears on the next start.
- Snapshot/ignore: start is pulsed again and kp is changed to 0xFFFF in cycle 2 -> the written data is unchanged and only one sequence occurs.
- Reset mid-op: h_reset=0 in cycle 3 -> HTRANS=0 and busy=0 immediately; after release, bus idle until the next start.
- Back-to-back: start=1 in the done cycle -> the second sequence's FIRST_ADDR is in cycle 7 with the new values.
